// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared opcodes, state encoding and width default for the ALU
//             arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   // Operand/result width of the shared ALU
   localparam int ALU_DW = 32;

   // ALU opcodes
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_NOT = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_BEQ = 3'b110;
   localparam logic [2:0] OP_BNE = 3'b111;

   // Response slot state: IDLE = empty, HOLD = result waiting for its owner
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin picker. A lone request wins outright; on
//             contention the requester that did not win last time wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

   // One-hot grant, or zero when disabled or nobody asks
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Shares one combinational 32-bit ALU between two requesters with
//             round-robin grant and a single-slot registered response.
//             Optional macro ALU_ARB_STATS_EN adds saturating grant/stall
//             counters.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DW        = ALU_DW,
   parameter int FIRST_PRI = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    req_valid,
   output logic [1:0]    req_ready,
   input  logic [DW-1:0] req_a0,
   input  logic [DW-1:0] req_a1,
   input  logic [DW-1:0] req_b0,
   input  logic [DW-1:0] req_b1,
   input  logic [2:0]    req_sel0,
   input  logic [2:0]    req_sel1,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_sel,
   input  logic [DW-1:0] alu_f,
   input  logic          alu_ovf,
   input  logic          alu_zero,
   output logic [1:0]    rsp_valid,
   input  logic [1:0]    rsp_ready,
   output logic [DW-1:0] rsp_f,
   output logic          rsp_ovf,
   output logic          rsp_zero
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]   grant_cnt0,
   output logic [15:0]   grant_cnt1,
   output logic [15:0]   stall_cnt
`endif
);

   // last_grant resets to the opposite of the first-priority requester
   localparam logic c_last_rst = (FIRST_PRI == 0) ? 1'b1 : 1'b0;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_owner;
   logic          r_last;
   logic [DW-1:0] r_f;
   logic          r_ovf;
   logic          r_zero;

   logic          w_slot_free;
   logic [1:0]    w_gnt;
   logic          w_take;
   logic [DW-1:0] w_f;
   logic          w_ovf;
   logic          w_zero;

   // Slot frees up when empty, or when the owner drains it this very cycle
   assign w_slot_free = (r_state == IDLE) || rsp_ready[r_owner];
   assign w_take      = |w_gnt;
   assign req_ready   = w_gnt;

   // Grant is held off while reset is asserted so no handshake completes
   rr_arb2 u_rr (
      .req  (req_valid),
      .last (r_last),
      .en   (w_slot_free & rst_n),
      .gnt  (w_gnt)
   );

   // Route the granted operation to the ALU; idle cycles issue a benign NOT
   always_comb begin
      alu_a   = req_a0;
      alu_b   = req_b0;
      alu_sel = OP_NOT;
      if (w_gnt[1]) begin
         alu_a   = req_a1;
         alu_b   = req_b1;
         alu_sel = req_sel1;
      end else if (w_gnt[0]) begin
         alu_sel = req_sel0;
      end
   end

   // Mask ALU outputs that are undefined or meaningless for the opcode
   always_comb begin
      w_f    = (alu_sel[2:1] == 2'b11) ? '0 : alu_f;
      w_ovf  = (alu_sel == OP_ADD) && alu_ovf;
      w_zero = (alu_sel[2:1] == 2'b11) && alu_zero;
   end

   // Slot state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: a new grant always (re)fills the slot, a drain empties it
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_take) w_state_nxt = HOLD;
         HOLD:    if (!w_take && rsp_ready[r_owner]) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Capture the normalised result and remember who owns it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f     <= '0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_owner <= 1'b0;
         r_last  <= c_last_rst;
      end else if (w_take) begin
         r_f     <= w_f;
         r_ovf   <= w_ovf;
         r_zero  <= w_zero;
         r_owner <= w_gnt[1];
         r_last  <= w_gnt[1];
      end
   end

   assign rsp_valid = (r_state == HOLD) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_f     = r_f;
   assign rsp_ovf   = r_ovf;
   assign rsp_zero  = r_zero;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] r_gcnt0;
   logic [15:0] r_gcnt1;
   logic [15:0] r_scnt;
   logic        w_stall;

   assign w_stall = (|req_valid) && !w_slot_free;

   // Saturating acceptance and stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gcnt0 <= '0;
         r_gcnt1 <= '0;
         r_scnt  <= '0;
      end else begin
         if (w_gnt[0] && (r_gcnt0 != 16'hFFFF)) r_gcnt0 <= r_gcnt0 + 16'd1;
         if (w_gnt[1] && (r_gcnt1 != 16'hFFFF)) r_gcnt1 <= r_gcnt1 + 16'd1;
         if (w_stall  && (r_scnt  != 16'hFFFF)) r_scnt  <= r_scnt  + 16'd1;
      end
   end

   assign grant_cnt0 = r_gcnt0;
   assign grant_cnt1 = r_gcnt1;
   assign stall_cnt  = r_scnt;
`endif

endmodule : alu_arbiter
`default_nettype wire
